// File: rtl/router_fsm_nport.sv
// router_fsm_nport: 1xN packet-router control FSM (header decode, load sequencing, back-pressure, drop)
// Ports:
//   clk, resetn (async active-low)
//   pkt_valid, din[ADDR_W], parity_done, low_pkt_valid, fifo_full  - source / register-block inputs
//   fifo_empty[NUM_PORTS], soft_rst[NUM_PORTS]                      - per-port FIFO status
//   detect_add, lfd_state, ld_state, full_state, laf_state,
//   rst_int_reg, write_enb_reg, busy, drop_state                    - Moore decodes of state
//   drop_cause (0 invalid address, 1 wait timeout), addr_out[ADDR_W] - latched packet info
module router_fsm_nport #(
  parameter int NUM_PORTS    = 3,
  parameter int ADDR_W       = 2,
  parameter int WAIT_TIMEOUT = 32
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 pkt_valid,
  input  logic [ADDR_W-1:0]    din,
  input  logic                 parity_done,
  input  logic                 low_pkt_valid,
  input  logic                 fifo_full,
  input  logic [NUM_PORTS-1:0] fifo_empty,
  input  logic [NUM_PORTS-1:0] soft_rst,
  output logic                 detect_add,
  output logic                 lfd_state,
  output logic                 ld_state,
  output logic                 full_state,
  output logic                 laf_state,
  output logic                 rst_int_reg,
  output logic                 write_enb_reg,
  output logic                 busy,
  output logic                 drop_state,
  output logic                 drop_cause,
  output logic [ADDR_W-1:0]    addr_out
);
  localparam int CW = (WAIT_TIMEOUT > 0) ? $clog2(WAIT_TIMEOUT + 1) : 1;
  localparam int NA = 2 ** ADDR_W;
  typedef enum logic [3:0] {
    DECODE_ADDRESS, LOAD_FIRST_DATA, LOAD_DATA, FIFO_FULL_STATE, LOAD_AFTER_FULL,
    LOAD_PARITY, CHECK_PARITY_ERROR, WAIT_TILL_EMPTY, DROP_PACKET
  } state_t;
  state_t state;
  logic [CW-1:0] wait_cnt;
  logic [NA-1:0] empty_ext, srst_ext;
  logic valid_addr, timeout;
  // widen per-port flags to the full address space so any din/addr_out indexes safely
  always_comb begin
    empty_ext = '0;
    empty_ext[NUM_PORTS-1:0] = fifo_empty;
    srst_ext = '0;
    srst_ext[NUM_PORTS-1:0] = soft_rst;
  end
  assign valid_addr = {1'b0, din} < (ADDR_W + 1)'(NUM_PORTS);
  assign timeout    = (WAIT_TIMEOUT > 0) && (wait_cnt == CW'(WAIT_TIMEOUT - 1));
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= DECODE_ADDRESS;
      addr_out   <= '0;
      wait_cnt   <= '0;
      drop_cause <= 1'b0;
    end else begin
      if (state == DECODE_ADDRESS && pkt_valid) addr_out <= din;
      // saturating: never wraps even if WAIT were somehow held past terminal count
      wait_cnt <= (state != WAIT_TILL_EMPTY) ? '0 :
                  (wait_cnt == CW'(WAIT_TIMEOUT)) ? wait_cnt : wait_cnt + CW'(1);
      if (srst_ext[addr_out]) state <= DECODE_ADDRESS;
      else begin
        case (state)
          DECODE_ADDRESS: begin
            if (pkt_valid && !valid_addr) drop_cause <= 1'b0;
            state <= !pkt_valid ? DECODE_ADDRESS : !valid_addr ? DROP_PACKET :
                     empty_ext[din] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
          end
          LOAD_FIRST_DATA:    state <= LOAD_DATA;
          LOAD_DATA:          state <= fifo_full ? FIFO_FULL_STATE : !pkt_valid ? LOAD_PARITY : LOAD_DATA;
          FIFO_FULL_STATE:    state <= fifo_full ? FIFO_FULL_STATE : LOAD_AFTER_FULL;
          LOAD_AFTER_FULL:    state <= parity_done ? DECODE_ADDRESS : low_pkt_valid ? LOAD_PARITY : LOAD_DATA;
          LOAD_PARITY:        state <= CHECK_PARITY_ERROR;
          CHECK_PARITY_ERROR: state <= fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
          WAIT_TILL_EMPTY: begin
            if (!empty_ext[addr_out] && timeout) drop_cause <= 1'b1;
            state <= empty_ext[addr_out] ? LOAD_FIRST_DATA : timeout ? DROP_PACKET : WAIT_TILL_EMPTY;
          end
          DROP_PACKET:        state <= pkt_valid ? DROP_PACKET : DECODE_ADDRESS;
          default:            state <= DECODE_ADDRESS;
        endcase
      end
    end
  end
  assign detect_add    = state == DECODE_ADDRESS;
  assign lfd_state     = state == LOAD_FIRST_DATA;
  assign ld_state      = state == LOAD_DATA;
  assign full_state    = state == FIFO_FULL_STATE;
  assign laf_state     = state == LOAD_AFTER_FULL;
  assign rst_int_reg   = state == CHECK_PARITY_ERROR;
  assign drop_state    = state == DROP_PACKET;
  assign write_enb_reg = ld_state | laf_state | (state == LOAD_PARITY);
  assign busy          = lfd_state | full_state | laf_state | (state == LOAD_PARITY) |
                         rst_int_reg | (state == WAIT_TILL_EMPTY);
endmodule

// File: tb/tb_router_fsm_nport.sv
// tb_router_fsm_nport: directed and randomized checks of router_fsm_nport (3 ports, wait timeout 4)
module tb_router_fsm_nport;
  localparam int NP = 3;
  localparam int WT = 4;
  // output vector order: detect,lfd,ld,full,laf,rst_int,wenb,busy,drop
  localparam logic [8:0] E_DEC  = 9'b100000000;
  localparam logic [8:0] E_LFD  = 9'b010000010;
  localparam logic [8:0] E_LD   = 9'b001000100;
  localparam logic [8:0] E_FULL = 9'b000100010;
  localparam logic [8:0] E_LAF  = 9'b000010110;
  localparam logic [8:0] E_LP   = 9'b000000110;
  localparam logic [8:0] E_CP   = 9'b000001010;
  localparam logic [8:0] E_WAIT = 9'b000000010;
  localparam logic [8:0] E_DROP = 9'b000000001;
  typedef enum {P_IDLE, P_HDR, P_PAY, P_STALL, P_RESUME, P_PAR, P_CHK, P_HOLD, P_DISCARD} phase_t;
  logic clk = 1'b0, resetn = 1'b0;
  logic pkt_valid = 0, parity_done = 0, low_pkt_valid = 0, fifo_full = 0;
  logic [1:0] din = '0;
  logic [2:0] fifo_empty = 3'b111, soft_rst = '0;
  logic detect_add, lfd_state, ld_state, full_state, laf_state, rst_int_reg;
  logic write_enb_reg, busy, drop_state, drop_cause;
  logic [1:0] addr_out;
  logic [8:0] dv;
  int tests_run = 0, tests_failed = 0;
  phase_t m_ph;
  logic [1:0] m_addr;
  int m_waited;
  logic m_cause;
  router_fsm_nport #(.NUM_PORTS(NP), .ADDR_W(2), .WAIT_TIMEOUT(WT)) dut (
    .clk(clk), .resetn(resetn), .pkt_valid(pkt_valid), .din(din), .parity_done(parity_done),
    .low_pkt_valid(low_pkt_valid), .fifo_full(fifo_full), .fifo_empty(fifo_empty), .soft_rst(soft_rst),
    .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state), .full_state(full_state),
    .laf_state(laf_state), .rst_int_reg(rst_int_reg), .write_enb_reg(write_enb_reg), .busy(busy),
    .drop_state(drop_state), .drop_cause(drop_cause), .addr_out(addr_out));
  assign dv = {detect_add, lfd_state, ld_state, full_state, laf_state, rst_int_reg, write_enb_reg, busy, drop_state};
  always #5 clk = ~clk;
  function automatic logic [8:0] exp_of(phase_t p);
    case (p)
      P_IDLE:   return E_DEC;
      P_HDR:    return E_LFD;
      P_PAY:    return E_LD;
      P_STALL:  return E_FULL;
      P_RESUME: return E_LAF;
      P_PAR:    return E_LP;
      P_CHK:    return E_CP;
      P_HOLD:   return E_WAIT;
      default:  return E_DROP;
    endcase
  endfunction
  task automatic model_init();
    m_ph = P_IDLE; m_addr = '0; m_waited = 0; m_cause = 1'b0;
  endtask
  // advance one clock; the reference model applies the packet rules to the inputs seen at the edge
  task automatic tick();
    phase_t n = m_ph;
    logic [1:0] na = m_addr;
    logic nc = m_cause;
    int nw = (m_ph == P_HOLD) ? m_waited + 1 : 0;
    if (m_ph == P_IDLE && pkt_valid) na = din;
    if (int'(m_addr) < NP && soft_rst[m_addr]) n = P_IDLE;
    else case (m_ph)
      P_IDLE:    if (pkt_valid) begin
                   if (int'(din) >= NP) begin n = P_DISCARD; nc = 1'b0; end
                   else n = fifo_empty[din] ? P_HDR : P_HOLD;
                 end
      P_HDR:     n = P_PAY;
      P_PAY:     n = fifo_full ? P_STALL : (!pkt_valid ? P_PAR : P_PAY);
      P_STALL:   if (!fifo_full) n = P_RESUME;
      P_RESUME:  n = parity_done ? P_IDLE : (low_pkt_valid ? P_PAR : P_PAY);
      P_PAR:     n = P_CHK;
      P_CHK:     n = fifo_full ? P_STALL : P_IDLE;
      P_HOLD:    if (fifo_empty[m_addr]) n = P_HDR;
                 else if (m_waited + 1 == WT) begin n = P_DISCARD; nc = 1'b1; end
      P_DISCARD: if (!pkt_valid) n = P_IDLE;
      default:   n = P_IDLE;
    endcase
    @(posedge clk); #1;
    m_ph = n; m_addr = na; m_cause = nc; m_waited = nw;
  endtask
  task automatic idle_inputs();
    pkt_valid = 0; din = '0; parity_done = 0; low_pkt_valid = 0; fifo_full = 0;
    fifo_empty = 3'b111; soft_rst = '0;
  endtask
  task automatic test_reset();
    idle_inputs(); resetn = 0; #3;
    tests_run++; if (dv !== E_DEC) begin tests_failed++; $display("FAIL reset_state got %b exp %b", dv, E_DEC); end
    tests_run++; if (addr_out !== 2'd0 || drop_cause !== 1'b0) begin tests_failed++; $display("FAIL reset_regs got addr=%0d cause=%b exp 0/0", addr_out, drop_cause); end
    @(posedge clk); #1; resetn = 1; model_init();
    tick();
    tests_run++; if (dv !== E_DEC) begin tests_failed++; $display("FAIL idle_hold got %b exp %b", dv, E_DEC); end
  endtask
  task automatic test_normal();
    int wcnt = 0;
    din = 2; pkt_valid = 1; tick();
    tests_run++; if (dv !== E_LFD || addr_out !== 2'd2) begin tests_failed++; $display("FAIL norm_lfd got %b addr=%0d exp %b addr=2", dv, addr_out, E_LFD); end
    for (int i = 0; i < 4; i++) begin
      tick(); wcnt += int'(write_enb_reg);
      tests_run++; if (dv !== E_LD) begin tests_failed++; $display("FAIL norm_ld%0d got %b exp %b", i, dv, E_LD); end
    end
    pkt_valid = 0; tick(); wcnt += int'(write_enb_reg);
    tests_run++; if (dv !== E_LP) begin tests_failed++; $display("FAIL norm_lp got %b exp %b", dv, E_LP); end
    tick(); wcnt += int'(write_enb_reg);
    tests_run++; if (dv !== E_CP) begin tests_failed++; $display("FAIL norm_cp got %b exp %b", dv, E_CP); end
    tick(); wcnt += int'(write_enb_reg);
    tests_run++; if (dv !== E_DEC) begin tests_failed++; $display("FAIL norm_dec got %b exp %b", dv, E_DEC); end
    tests_run++; if (wcnt != 5) begin tests_failed++; $display("FAIL norm_wenb_cycles got %0d exp 5", wcnt); end
  endtask
  task automatic test_full();
    din = 0; pkt_valid = 1; tick(); tick(); fifo_full = 1; tick();
    tests_run++; if (dv !== E_FULL || busy !== 1'b1) begin tests_failed++; $display("FAIL full_enter got %b exp %b", dv, E_FULL); end
    tick();
    tests_run++; if (dv !== E_FULL) begin tests_failed++; $display("FAIL full_hold got %b exp %b", dv, E_FULL); end
    fifo_full = 0; tick();
    tests_run++; if (dv !== E_LAF) begin tests_failed++; $display("FAIL full_laf got %b exp %b", dv, E_LAF); end
    low_pkt_valid = 1; tick();
    tests_run++; if (dv !== E_LP) begin tests_failed++; $display("FAIL full_laf_lp got %b exp %b", dv, E_LP); end
    low_pkt_valid = 0; pkt_valid = 0; tick(); tick();
    tests_run++; if (dv !== E_DEC) begin tests_failed++; $display("FAIL full_done got %b exp %b", dv, E_DEC); end
  endtask
  task automatic test_drop_invalid();
    din = 3; pkt_valid = 1; tick();
    tests_run++; if (dv !== E_DROP || drop_cause !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("FAIL drop_enter got %b cause=%b exp %b cause=0", dv, drop_cause, E_DROP); end
    tests_run++; if (addr_out !== 2'd3) begin tests_failed++; $display("FAIL drop_addr got %0d exp 3", addr_out); end
    tick();
    tests_run++; if (dv !== E_DROP) begin tests_failed++; $display("FAIL drop_hold got %b exp %b", dv, E_DROP); end
    pkt_valid = 0; tick();
    tests_run++; if (dv !== E_DEC) begin tests_failed++; $display("FAIL drop_exit got %b exp %b", dv, E_DEC); end
  endtask
  task automatic test_wait_timeout();
    din = 1; pkt_valid = 1; fifo_empty = 3'b101;
    for (int i = 0; i < WT; i++) begin
      tick();
      tests_run++; if (dv !== E_WAIT) begin tests_failed++; $display("FAIL wto_wait%0d got %b exp %b", i, dv, E_WAIT); end
    end
    tick();
    tests_run++; if (dv !== E_DROP || drop_cause !== 1'b1) begin tests_failed++; $display("FAIL wto_drop got %b cause=%b exp %b cause=1", dv, drop_cause, E_DROP); end
    pkt_valid = 0; fifo_empty = 3'b111; tick();
    tests_run++; if (dv !== E_DEC || drop_cause !== 1'b1) begin tests_failed++; $display("FAIL wto_exit got %b cause=%b exp %b cause=1", dv, drop_cause, E_DEC); end
  endtask
  task automatic test_wait_empty();
    din = 1; pkt_valid = 1; fifo_empty = 3'b101;
    for (int i = 0; i < WT; i++) tick();
    tests_run++; if (dv !== E_WAIT) begin tests_failed++; $display("FAIL wem_last_wait got %b exp %b", dv, E_WAIT); end
    fifo_empty = 3'b111; tick();
    tests_run++; if (dv !== E_LFD) begin tests_failed++; $display("FAIL wem_lfd got %b exp %b", dv, E_LFD); end
    tick(); pkt_valid = 0; tick(); tick(); tick();
    tests_run++; if (dv !== E_DEC) begin tests_failed++; $display("FAIL wem_done got %b exp %b", dv, E_DEC); end
  endtask
  task automatic test_soft_rst();
    din = 1; pkt_valid = 1; tick(); tick();
    soft_rst = 3'b100; tick();
    tests_run++; if (dv !== E_LD) begin tests_failed++; $display("FAIL srst_other got %b exp %b", dv, E_LD); end
    soft_rst = 3'b010; tick();
    tests_run++; if (dv !== E_DEC) begin tests_failed++; $display("FAIL srst_sel got %b exp %b", dv, E_DEC); end
    soft_rst = '0; pkt_valid = 0; tick();
  endtask
  task automatic test_async_reset();
    din = 2; pkt_valid = 1; tick(); tick(); fifo_full = 1; tick(); fifo_full = 0; tick();
    tests_run++; if (dv !== E_LAF || addr_out !== 2'd2) begin tests_failed++; $display("FAIL async_pre got %b addr=%0d exp %b addr=2", dv, addr_out, E_LAF); end
    #2 resetn = 0; #1;
    tests_run++; if (dv !== E_DEC || addr_out !== 2'd0 || drop_cause !== 1'b0) begin tests_failed++; $display("FAIL async_rst got %b addr=%0d cause=%b exp %b addr=0 cause=0", dv, addr_out, drop_cause, E_DEC); end
    idle_inputs(); resetn = 1; model_init(); tick();
  endtask
  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      pkt_valid = $urandom_range(0, 3) != 0;
      din = 2'($urandom_range(0, 3));
      fifo_full = $urandom_range(0, 3) == 0;
      fifo_empty = 3'($urandom);
      parity_done = $urandom_range(0, 3) == 0;
      low_pkt_valid = $urandom_range(0, 3) == 0;
      soft_rst = ($urandom_range(0, 15) == 0) ? 3'($urandom) : 3'b000;
      tick();
      tests_run++;
      if ({dv, addr_out, drop_cause} !== {exp_of(m_ph), m_addr, m_cause}) begin
        tests_failed++;
        $display("FAIL rand_cycle%0d got out=%b addr=%0d cause=%b exp out=%b addr=%0d cause=%b",
                 i, dv, addr_out, drop_cause, exp_of(m_ph), m_addr, m_cause);
      end
    end
    idle_inputs();
  endtask
  initial begin
    test_reset();
    test_normal();
    test_full();
    test_drop_invalid();
    test_wait_timeout();
    test_wait_empty();
    test_soft_rst();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
